// File: rtl/color_uart_reporter.sv
// Debounces detector colour samples (one per frame strobe) and reports each confirmed
// colour change as an ASCII letter plus LF on an 8N1 UART line.
module color_uart_reporter #(
  parameter int CLKS_PER_BIT = 104,
  parameter int DEBOUNCE     = 2
) (
  input  logic       clk_1MHz,
  input  logic       rst_n,
  input  logic [1:0] filter,
  input  logic [1:0] color,
  output logic       tx,
  output logic       busy,
  output logic [1:0] reported_color,
  output logic [7:0] report_count
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0] RUN_MAX = 4'(DEBOUNCE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        filter_q;
  logic [1:0]        cand_q, cand_d;
  logic [3:0]        run_q, run_d;
  logic [1:0]        last_q, last_d;
  logic              pend_q, pend_d;
  logic [1:0]        pend_col_q, pend_col_d;
  logic [1:0]        cur_col_q, cur_col_d;
  logic              byte_idx_q, byte_idx_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shreg_q, shreg_d;
  logic [1:0]        rep_col_q, rep_col_d;
  logic [7:0]        rep_cnt_q, rep_cnt_d;

  logic       smp;
  logic       confirm;
  logic       req;
  logic       baud_end;
  logic       frame_done;
  logic       restart;
  logic [1:0] restart_col;

  function automatic logic [7:0] ascii_byte(input logic [1:0] c);
    case (c)
      2'd1:    ascii_byte = 8'h52;
      2'd2:    ascii_byte = 8'h47;
      2'd3:    ascii_byte = 8'h42;
      default: ascii_byte = 8'h00;
    endcase
  endfunction

  // Rising edge of filter==2 is the once-per-frame sample point.
  always_comb begin
    smp     = (filter == 2'd2) && (filter_q != 2'd2);
    cand_d  = cand_q;
    run_d   = run_q;
    confirm = 1'b0;
    if (smp) begin
      if (color == 2'd0) begin
        cand_d = 2'd0;
        run_d  = 4'd0;
      end else if (color == cand_q) begin
        if (run_q < RUN_MAX) begin
          run_d   = run_q + 4'd1;
          confirm = ((run_q + 4'd1) == RUN_MAX);
        end
      end else begin
        cand_d  = color;
        run_d   = 4'd1;
        confirm = (RUN_MAX == 4'd1);
      end
    end
    req    = confirm && (color != last_q);
    last_d = req ? color : last_q;
  end

  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q;
    bit_d       = bit_q;
    byte_idx_d  = byte_idx_q;
    shreg_d     = shreg_q;
    cur_col_d   = cur_col_q;
    pend_d      = pend_q;
    pend_col_d  = pend_col_q;
    rep_col_d   = rep_col_q;
    rep_cnt_d   = rep_cnt_q;
    frame_done  = 1'b0;
    baud_end    = (baud_q == BAUD_LAST);
    // A fresh request beats a stale pending one (latest wins).
    restart     = req || pend_q;
    restart_col = req ? color : pend_col_q;

    case (state_q)
      S_IDLE: begin
        if (restart) begin
          state_d    = S_START;
          baud_d     = '0;
          byte_idx_d = 1'b0;
          cur_col_d  = restart_col;
          pend_d     = 1'b0;
        end
      end
      S_START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          state_d = S_DATA;
          shreg_d = byte_idx_q ? 8'h0A : ascii_byte(cur_col_q);
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_DATA: begin
        if (baud_end) begin
          baud_d  = '0;
          shreg_d = {1'b0, shreg_q[7:1]};
          if (bit_q == 3'd7) state_d = S_STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_STOP: begin
        if (baud_end) begin
          baud_d = '0;
          if (!byte_idx_q) begin
            byte_idx_d = 1'b1;
            state_d    = S_START;
          end else begin
            frame_done = 1'b1;
            rep_col_d  = cur_col_q;
            rep_cnt_d  = rep_cnt_q + 8'd1;
            if (restart) begin
              state_d    = S_START;
              byte_idx_d = 1'b0;
              cur_col_d  = restart_col;
              pend_d     = 1'b0;
            end else begin
              state_d = S_IDLE;
            end
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (req && (state_q != S_IDLE) && !frame_done) begin
      pend_d     = 1'b1;
      pend_col_d = color;
    end
  end

  always_ff @(posedge clk_1MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      filter_q   <= 2'd0;
      cand_q     <= 2'd0;
      run_q      <= 4'd0;
      last_q     <= 2'd0;
      pend_q     <= 1'b0;
      pend_col_q <= 2'd0;
      cur_col_q  <= 2'd0;
      byte_idx_q <= 1'b0;
      baud_q     <= '0;
      bit_q      <= 3'd0;
      shreg_q    <= 8'hFF;
      rep_col_q  <= 2'd0;
      rep_cnt_q  <= 8'd0;
    end else begin
      state_q    <= state_d;
      filter_q   <= filter;
      cand_q     <= cand_d;
      run_q      <= run_d;
      last_q     <= last_d;
      pend_q     <= pend_d;
      pend_col_q <= pend_col_d;
      cur_col_q  <= cur_col_d;
      byte_idx_q <= byte_idx_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      rep_col_q  <= rep_col_d;
      rep_cnt_q  <= rep_cnt_d;
    end
  end

  // tx depends only on flops, so reset forces it high without waiting for a clock.
  assign tx             = (state_q == S_START) ? 1'b0 :
                          (state_q == S_DATA)  ? shreg_q[0] : 1'b1;
  assign busy           = (state_q != S_IDLE);
  assign reported_color = rep_col_q;
  assign report_count   = rep_cnt_q;

endmodule
